wb_cp0_exc: RTL and testbench
=============================

Name: wb_cp0_exc

Overview:
Parametrised writeback stage of the five-stage pipeline: commits register-file and HI/LO writes and owns the CP0 exception and interrupt unit.
Generalises the syscall-only scheme to:
- multiple synchronous exception codes, with BadVAddr and branch-delay-slot tracking;
- NUM_HWINT masked hardware interrupt lines;
- a configurable exception vector;
- an optional COUNT/COMPARE timer.
Produces the redirect bus and the cancel signal that flush the earlier pipeline stages.

Parameters:
NUM_HWINT, 6, number of hardware interrupt inputs (1..6); line i maps to CAUSE.IP[i+2].
EXC_VECTOR, 32'h0000_0000, redirect PC for every exception and interrupt.
COUNT_DIV, 2, COUNT increments once every COUNT_DIV cycles (1..16).

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
WB_valid  in  1  instruction present in WB
wb_pc  in  32  PC of WB instruction
wb_wen  in  1  register-file write request
wb_wdest  in  5  destination register
wb_result  in  32  ALU/mem result; HI write data; mtc0 data
wb_lo_result  in  32  LO write data
wb_hi_write  in  1  write HI
wb_lo_write  in  1  write LO
wb_mfhi  in  1  read HI
wb_mflo  in  1  read LO
wb_mtc0  in  1  write CP0 register
wb_mfc0  in  1  read CP0 register
wb_cp0r_addr  in  8  {reg[4:0],sel[2:0]}
wb_exc_valid  in  1  synchronous exception raised upstream
wb_exc_code  in  5  ExcCode (4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
wb_badvaddr  in  32  faulting address for codes 4/5
wb_bd  in  1  instruction is in a branch delay slot
wb_eret  in  1  eret
hw_int  in  NUM_HWINT  level-sensitive interrupt requests
rf_wen  out  1  register-file write enable
rf_wdest  out  5  register-file write address
rf_wdata  out  32  register-file write data / bypass value
WB_over  out  1  WB finished (= WB_valid)
WB_wdest  out  5  rf_wdest gated by WB_valid, for hazard detection
cancel  out  1  flush IF–MEM
exc_bus  out  33  {redirect_valid, redirect_pc}
HI_data  out  32  HI register
LO_data  out  32  LO register

Behaviour:
Reset values:
- STATUS.IE=0, EXL=0, IM=0.
- CAUSE all 0; EPC=0; BadVAddr=0; HI=LO=0; COUNT=COMPARE=0; prescaler=0; hw_int sync register=0.
- All outputs are 0 while reset is asserted.

CP0 register map (unimplemented bits read 0; unmapped addresses read 0, writes ignored):
- STATUS {12,0}: IM[15:8] R/W, EXL[1] R/W, IE[0] R/W.
- CAUSE {13,0}: BD[31] RO, TI[30] RO, IP[15:10] RO, IP[9:8] R/W, ExcCode[6:2] RO.
- EPC {14,0}: R/W.
- BadVAddr {8,0}: RO.
- COUNT {9,0}: R/W.
- COMPARE {11,0}: R/W.

Interrupts:
- hw_int is registered once, so 1-cycle input-to-IP latency.
- IP[7] = hw_int sync[5] | TI.
- int_req = IE & ~EXL & |(IP & IM).

Take decision, evaluated only while WB_valid. Priority: interrupt > wb_exc_valid > wb_eret > normal commit.

Exception or interrupt taken (posedge):
- EXL=1.
- ExcCode = 0 for an interrupt, else wb_exc_code.
- BD = wb_bd; EPC = wb_bd ? wb_pc-4 : wb_pc.
- BadVAddr = wb_badvaddr only for codes 4/5.
- Same cycle, combinational: exc_bus = {1, EXC_VECTOR} and cancel = 1.
- The instruction does not commit: rf_wen=0, no HI/LO write, mtc0 ignored.

eret:
- EXL=0; exc_bus = {1, EPC}; cancel = 1.

Normal commit:
- rf_wen = wb_wen & WB_valid.
- rf_wdata = mfhi ? HI : mflo ? LO : mfc0 ? cp0_rdata : wb_result.
- HI/LO and mtc0 writes are enabled only by WB_valid.

Timer:
- Prescaler counts 0..COUNT_DIV-1; COUNT increments at the wrap, with 32-bit wrap-around.
- TI is set on the cycle COUNT increments to a value equal to COMPARE.
- An mtc0 write to COMPARE clears TI.
- An mtc0 write to COUNT loads the value and clears the prescaler.

Simultaneous events:
- mtc0 write vs hardware update of the same field: mtc0 wins.
- An increment in the same cycle as an mtc0 COUNT write is lost.

Other rules:
- mfc0 returns pre-update state; no same-cycle write forwarding.
- A reset asserted mid-operation overrides everything the same cycle.

Optional Feature:
Macro CP0_TIMER_EN.
- Defined: COUNT/COMPARE, prescaler and TI are implemented as above.
- Undefined: COUNT and COMPARE read 0; writes to them are ignored; TI is tied to 0; no timer logic is synthesised.

Test Plan:
1. syscall: WB_valid=1, wb_exc_code=8, wb_pc=0x1C, wb_wen=1 -> exc_bus=0x1_0000_0000 and cancel=1 that cycle; rf_wen=0. Next cycle: EPC=0x1C, ExcCode=8, EXL=1.
2. AdEL in a delay slot: wb_bd=1, wb_pc=0x40, wb_badvaddr=0x1001 -> EPC=0x3C, BD=1, BadVAddr=0x1001. A following eret -> exc_bus={1,0x3C}, EXL=0.
3. Interrupt: mtc0 STATUS=0x0401, then hw_int[0] held high -> two cycles later, with the next valid instruction at pc=0x80: exc taken, ExcCode=0, EPC=0x80. Same stimulus with EXL=1 -> no redirect.
4. Timer (CP0_TIMER_EN, COUNT_DIV=2): COMPARE=5, COUNT=0 -> TI rises 10 cycles after the COUNT write. A COMPARE write clears TI. Without the macro: reading COUNT returns 0 and TI stays 0.
5. Simultaneous: wb_exc_valid together with a pending enabled interrupt -> ExcCode=0 (interrupt wins). mtc0 EPC together with wb_exc_valid on the same instruction -> EPC=pc (mtc0 suppressed).
6. Reset asserted while EXL=1 and TI=1 -> all CP0 fields 0 next cycle; exc_bus=0.

Source files
------------

// File: rtl/wb_cp0_exc_if.sv
// Writeback-stage bus: instruction fields in from MEM, commit/redirect results out.
interface wb_cp0_exc_if #(
  parameter int unsigned NUM_HWINT = 6
);
  logic                 WB_valid;
  logic [31:0]          wb_pc;
  logic                 wb_wen;
  logic [4:0]           wb_wdest;
  logic [31:0]          wb_result;
  logic [31:0]          wb_lo_result;
  logic                 wb_hi_write;
  logic                 wb_lo_write;
  logic                 wb_mfhi;
  logic                 wb_mflo;
  logic                 wb_mtc0;
  logic                 wb_mfc0;
  logic [7:0]           wb_cp0r_addr;
  logic                 wb_exc_valid;
  logic [4:0]           wb_exc_code;
  logic [31:0]          wb_badvaddr;
  logic                 wb_bd;
  logic                 wb_eret;
  logic [NUM_HWINT-1:0] hw_int;

  logic                 rf_wen;
  logic [4:0]           rf_wdest;
  logic [31:0]          rf_wdata;
  logic                 WB_over;
  logic [4:0]           WB_wdest;
  logic                 cancel;
  logic [32:0]          exc_bus;
  logic [31:0]          HI_data;
  logic [31:0]          LO_data;

  modport master (
    output WB_valid, wb_pc, wb_wen, wb_wdest, wb_result, wb_lo_result, wb_hi_write,
           wb_lo_write, wb_mfhi, wb_mflo, wb_mtc0, wb_mfc0, wb_cp0r_addr, wb_exc_valid,
           wb_exc_code, wb_badvaddr, wb_bd, wb_eret, hw_int,
    input  rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, cancel, exc_bus, HI_data, LO_data
  );

  modport slave (
    input  WB_valid, wb_pc, wb_wen, wb_wdest, wb_result, wb_lo_result, wb_hi_write,
           wb_lo_write, wb_mfhi, wb_mflo, wb_mtc0, wb_mfc0, wb_cp0r_addr, wb_exc_valid,
           wb_exc_code, wb_badvaddr, wb_bd, wb_eret, hw_int,
    output rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, cancel, exc_bus, HI_data, LO_data
  );
endinterface

// File: rtl/wb_cp0_exc.sv
// Writeback stage with CP0 exception/interrupt unit, HI/LO and redirect generation.
// Define CP0_TIMER_EN to build the COUNT/COMPARE timer; otherwise those registers read 0.
module wb_cp0_exc #(
  parameter int unsigned NUM_HWINT  = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0000,
  parameter int unsigned COUNT_DIV  = 2
) (
  input logic         clk,
  input logic         reset,
  wb_cp0_exc_if.slave wb
);
  localparam logic [7:0] AddrStatus   = 8'h60;
  localparam logic [7:0] AddrCause    = 8'h68;
  localparam logic [7:0] AddrEpc      = 8'h70;
  localparam logic [7:0] AddrBadVAddr = 8'h40;
  localparam logic [7:0] AddrCount    = 8'h48;
  localparam logic [7:0] AddrCompare  = 8'h58;

  if (NUM_HWINT < 1 || NUM_HWINT > 6 || COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_param
    $error("wb_cp0_exc: parameter out of range");
  end

  logic                 ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
  logic [7:0]           im_q, im_d;
  logic [1:0]           ip_sw_q, ip_sw_d;
  logic [4:0]           exc_code_q, exc_code_d;
  logic [31:0]          epc_q, epc_d, badvaddr_q, badvaddr_d, hi_q, hi_d, lo_q, lo_d;
  logic [NUM_HWINT-1:0] hw_sync_q;
  logic [5:0]           hw_ext;
  logic [7:0]           ip;
  logic                 ti;
  logic [31:0]          count_val, compare_val, cp0_rdata;
  logic                 int_req, take_int, take_exc, do_eret, commit, mtc0_we;

  always_comb begin
    hw_ext                  = '0;
    hw_ext[NUM_HWINT-1:0]   = hw_sync_q;
    ip       = {hw_ext[5] | ti, hw_ext[4:0], ip_sw_q};
    int_req  = ie_q & ~exl_q & (|(ip & im_q));
    take_int = wb.WB_valid & int_req;
    take_exc = take_int | (wb.WB_valid & wb.wb_exc_valid);
    do_eret  = wb.WB_valid & ~take_exc & wb.wb_eret;
    commit   = wb.WB_valid & ~take_exc & ~wb.wb_eret;
    mtc0_we  = commit & wb.wb_mtc0;
  end

  always_comb begin
    unique case (wb.wb_cp0r_addr)
      AddrStatus:   cp0_rdata = {16'b0, im_q, 6'b0, exl_q, ie_q};
      AddrCause:    cp0_rdata = {bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
      AddrEpc:      cp0_rdata = epc_q;
      AddrBadVAddr: cp0_rdata = badvaddr_q;
      AddrCount:    cp0_rdata = count_val;
      AddrCompare:  cp0_rdata = compare_val;
      default:      cp0_rdata = '0;
    endcase
  end

  always_comb begin
    ie_d       = ie_q;
    exl_d      = exl_q;
    im_d       = im_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (take_exc) begin
      exl_d      = 1'b1;
      exc_code_d = take_int ? 5'd0 : wb.wb_exc_code;
      bd_d       = wb.wb_bd;
      epc_d      = wb.wb_bd ? wb.wb_pc - 32'd4 : wb.wb_pc;
      if (!take_int && (wb.wb_exc_code == 5'd4 || wb.wb_exc_code == 5'd5)) begin
        badvaddr_d = wb.wb_badvaddr;
      end
    end else if (do_eret) begin
      exl_d = 1'b0;
    end
    if (commit && wb.wb_hi_write) hi_d = wb.wb_result;
    if (commit && wb.wb_lo_write) lo_d = wb.wb_lo_result;
    if (mtc0_we && wb.wb_cp0r_addr == AddrStatus) begin
      im_d  = wb.wb_result[15:8];
      exl_d = wb.wb_result[1];
      ie_d  = wb.wb_result[0];
    end
    if (mtc0_we && wb.wb_cp0r_addr == AddrCause) ip_sw_d = wb.wb_result[9:8];
    if (mtc0_we && wb.wb_cp0r_addr == AddrEpc)   epc_d   = wb.wb_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      hw_sync_q  <= '0;
    end else begin
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      hw_sync_q  <= wb.hw_int;
    end
  end

`ifdef CP0_TIMER_EN
  logic [3:0]  pre_q, pre_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        ti_q, ti_d, tick;

  always_comb begin
    tick      = (pre_q == 4'(COUNT_DIV - 1));
    pre_d     = tick ? 4'd0 : pre_q + 4'd1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (tick && (count_q + 32'd1 == compare_q)) ti_d = 1'b1;
    // Software writes take precedence; a COUNT write swallows that cycle's increment.
    if (mtc0_we && wb.wb_cp0r_addr == AddrCount) begin
      count_d = wb.wb_result;
      pre_d   = 4'd0;
      ti_d    = ti_q;
    end
    if (mtc0_we && wb.wb_cp0r_addr == AddrCompare) begin
      compare_d = wb.wb_result;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_val   = count_q;
  assign compare_val = compare_q;
  assign ti          = ti_q;
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign ti          = 1'b0;
`endif

  always_comb begin
    wb.rf_wen   = ~reset & commit & wb.wb_wen;
    wb.rf_wdest = reset ? 5'd0 : wb.wb_wdest;
    wb.WB_over  = ~reset & wb.WB_valid;
    wb.WB_wdest = (reset || !wb.WB_valid) ? 5'd0 : wb.wb_wdest;
    wb.cancel   = ~reset & (take_exc | do_eret);
    wb.HI_data  = reset ? 32'd0 : hi_q;
    wb.LO_data  = reset ? 32'd0 : lo_q;
    if (reset)         wb.rf_wdata = '0;
    else if (wb.wb_mfhi) wb.rf_wdata = hi_q;
    else if (wb.wb_mflo) wb.rf_wdata = lo_q;
    else if (wb.wb_mfc0) wb.rf_wdata = cp0_rdata;
    else                 wb.rf_wdata = wb.wb_result;
    if (reset)         wb.exc_bus = '0;
    else if (take_exc) wb.exc_bus = {1'b1, EXC_VECTOR};
    else if (do_eret)  wb.exc_bus = {1'b1, epc_q};
    else               wb.exc_bus = '0;
  end
endmodule

// File: tb/tb_wb_cp0_exc.sv
// Directed self-checking bench for wb_cp0_exc: exceptions, eret, interrupts, timer, reset.
module tb_wb_cp0_exc;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  wb_cp0_exc_if #(.NUM_HWINT(6)) bus ();

  wb_cp0_exc #(
    .NUM_HWINT (6),
    .EXC_VECTOR(32'h0000_0000),
    .COUNT_DIV (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .wb   (bus)
  );

  localparam logic [7:0] AStatus = 8'h60, ACause = 8'h68, AEpc = 8'h70;
  localparam logic [7:0] ABad = 8'h40, ACount = 8'h48, ACompare = 8'h58;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Move to the next negedge and clear all instruction fields (hw_int is left alone).
  task automatic nxt();
    @(negedge clk);
    bus.WB_valid = 0; bus.wb_pc = '0; bus.wb_wen = 0; bus.wb_wdest = '0;
    bus.wb_result = '0; bus.wb_lo_result = '0; bus.wb_hi_write = 0; bus.wb_lo_write = 0;
    bus.wb_mfhi = 0; bus.wb_mflo = 0; bus.wb_mtc0 = 0; bus.wb_mfc0 = 0;
    bus.wb_cp0r_addr = '0; bus.wb_exc_valid = 0; bus.wb_exc_code = '0;
    bus.wb_badvaddr = '0; bus.wb_bd = 0; bus.wb_eret = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    nxt();
    bus.WB_valid = 1; bus.wb_mfc0 = 1; bus.wb_cp0r_addr = a;
    #1 v = bus.rf_wdata;
  endtask

  task automatic chk_cp0(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, {32'd0, v}, {32'd0, exp});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    nxt();
    bus.WB_valid = 1; bus.wb_mtc0 = 1; bus.wb_cp0r_addr = a; bus.wb_result = d;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          first_ti;
    bus.hw_int = '0;
    reset = 1;
    nxt();
    bus.WB_valid = 1; bus.wb_wen = 1; bus.wb_exc_valid = 1; bus.wb_result = 32'h55;
    #1;
    chk("rst_rf_wen", 64'(bus.rf_wen), 64'd0);
    chk("rst_exc_bus", 64'(bus.exc_bus), 64'd0);
    chk("rst_cancel", 64'(bus.cancel), 64'd0);
    nxt();
    reset = 0;
    chk_cp0("rst_status", AStatus, 32'h0);
    chk_cp0("rst_cause", ACause, 32'h0);

    // syscall
    nxt();
    bus.WB_valid = 1; bus.wb_exc_valid = 1; bus.wb_exc_code = 5'd8; bus.wb_pc = 32'h1C;
    bus.wb_wen = 1; bus.wb_wdest = 5'd2;
    #1;
    chk("sys_exc_bus", 64'(bus.exc_bus), 64'h1_0000_0000);
    chk("sys_cancel", 64'(bus.cancel), 64'd1);
    chk("sys_rf_wen", 64'(bus.rf_wen), 64'd0);
    chk_cp0("sys_epc", AEpc, 32'h1C);
    chk_cp0("sys_cause", ACause, 32'h20);
    chk_cp0("sys_status", AStatus, 32'h2);

    // AdEL in a delay slot, then eret
    nxt();
    bus.WB_valid = 1; bus.wb_exc_valid = 1; bus.wb_exc_code = 5'd4; bus.wb_bd = 1;
    bus.wb_pc = 32'h40; bus.wb_badvaddr = 32'h1001;
    #1;
    chk("adel_exc_bus", 64'(bus.exc_bus), 64'h1_0000_0000);
    chk_cp0("adel_epc", AEpc, 32'h3C);
    chk_cp0("adel_cause", ACause, 32'h8000_0010);
    chk_cp0("adel_badva", ABad, 32'h1001);
    nxt();
    bus.WB_valid = 1; bus.wb_eret = 1;
    #1;
    chk("eret_exc_bus", 64'(bus.exc_bus), 64'h1_0000_003C);
    chk("eret_cancel", 64'(bus.cancel), 64'd1);
    chk_cp0("eret_status", AStatus, 32'h0);

    // normal commit with HI/LO
    nxt();
    bus.WB_valid = 1; bus.wb_wen = 1; bus.wb_wdest = 5'd3; bus.wb_result = 32'hDEAD_BEEF;
    bus.wb_hi_write = 1; bus.wb_lo_write = 1; bus.wb_lo_result = 32'h2222;
    #1;
    chk("cm_rf_wen", 64'(bus.rf_wen), 64'd1);
    chk("cm_wdata", 64'(bus.rf_wdata), 64'hDEAD_BEEF);
    chk("cm_wb_wdest", 64'(bus.WB_wdest), 64'd3);
    chk("cm_exc_bus", 64'(bus.exc_bus), 64'd0);
    nxt();
    bus.WB_valid = 1; bus.wb_wen = 1; bus.wb_mfhi = 1; bus.wb_result = 32'h7;
    #1;
    chk("mfhi", 64'(bus.rf_wdata), 64'hDEAD_BEEF);
    nxt();
    bus.WB_valid = 1; bus.wb_wen = 1; bus.wb_mflo = 1;
    #1;
    chk("mflo", 64'(bus.rf_wdata), 64'h2222);

    // hardware interrupt
    wr(AStatus, 32'h0401);
    nxt();
    bus.hw_int[0] = 1'b1;
    #1;
    nxt();
    bus.WB_valid = 1; bus.wb_pc = 32'h80; bus.wb_wen = 1;
    #1;
    chk("int_exc_bus", 64'(bus.exc_bus), 64'h1_0000_0000);
    chk("int_rf_wen", 64'(bus.rf_wen), 64'd0);
    chk_cp0("int_cause", ACause, 32'h400);
    chk_cp0("int_epc", AEpc, 32'h80);
    chk_cp0("int_status", AStatus, 32'h403);
    nxt();
    bus.WB_valid = 1; bus.wb_pc = 32'h84; bus.wb_wen = 1;
    #1;
    chk("int_exl_bus", 64'(bus.exc_bus), 64'd0);
    chk("int_exl_wen", 64'(bus.rf_wen), 64'd1);

    // interrupt beats a simultaneous synchronous exception
    nxt();
    bus.WB_valid = 1; bus.wb_eret = 1;
    #1;
    chk("eret2_bus", 64'(bus.exc_bus), 64'h1_0000_0080);
    nxt();
    bus.WB_valid = 1; bus.wb_exc_valid = 1; bus.wb_exc_code = 5'd12; bus.wb_pc = 32'h90;
    #1;
    chk("pri_exc_bus", 64'(bus.exc_bus), 64'h1_0000_0000);
    chk_cp0("pri_cause", ACause, 32'h400);
    nxt();
    bus.hw_int[0] = 1'b0;
    bus.WB_valid = 1; bus.wb_eret = 1;
    #1;
    chk("eret3_bus", 64'(bus.exc_bus), 64'h1_0000_0090);
    // mtc0 EPC on a faulting instruction is suppressed
    nxt();
    bus.WB_valid = 1; bus.wb_mtc0 = 1; bus.wb_cp0r_addr = AEpc; bus.wb_result = 32'h1234;
    bus.wb_exc_valid = 1; bus.wb_exc_code = 5'd10; bus.wb_pc = 32'hA0;
    #1;
    chk_cp0("mtc0_sup_epc", AEpc, 32'hA0);
    chk_cp0("mtc0_sup_cause", ACause, 32'h28);

`ifdef CP0_TIMER_EN
    wr(ACompare, 32'd5);
    wr(ACount, 32'd0);
    first_ti = 0;
    for (int i = 1; i <= 12; i++) begin
      rd(ACause, v);
      if (v[30] && first_ti == 0) first_ti = i;
    end
    chk("ti_rise_cycle", 64'(first_ti), 64'd11);
    chk_cp0("count_val", ACount, 32'd6);
`else
    wr(ACount, 32'h55);
    chk_cp0("count_zero", ACount, 32'd0);
    wr(ACompare, 32'd1);
    first_ti = 0;
    for (int i = 1; i <= 6; i++) begin
      rd(ACause, v);
      if (v[30] && first_ti == 0) first_ti = i;
    end
    chk("ti_never", 64'(first_ti), 64'd0);
    chk_cp0("compare_zero", ACompare, 32'd0);
`endif

    // reset mid-operation with EXL set (and TI set in the timer build)
    nxt();
    reset = 1;
    bus.WB_valid = 1; bus.wb_exc_valid = 1; bus.wb_exc_code = 5'd8; bus.wb_wen = 1;
    #1;
    chk("mid_rst_bus", 64'(bus.exc_bus), 64'd0);
    chk("mid_rst_cancel", 64'(bus.cancel), 64'd0);
    nxt();
    reset = 0;
    chk_cp0("post_rst_status", AStatus, 32'h0);
    chk_cp0("post_rst_cause", ACause, 32'h0);
    chk_cp0("post_rst_epc", AEpc, 32'h0);
    chk_cp0("post_rst_badva", ABad, 32'h0);
    chk("post_rst_hi", 64'(bus.HI_data), 64'd0);

`ifdef CP0_TIMER_EN
    wr(ACompare, 32'd2);
    wr(ACount, 32'd0);
    first_ti = 0;
    for (int i = 1; i <= 10; i++) begin
      rd(ACause, v);
      if (v[30]) begin
        first_ti = i;
        break;
      end
    end
    chk("ti_again", 64'(first_ti != 0), 64'd1);
    wr(ACompare, 32'd7);
    rd(ACause, v);
    chk("ti_cleared", 64'(v[30]), 64'd0);
`endif

    nxt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
